tile_digit_renderer: RTL and testbench

- Consumer side of the digit font ROM: reads glyph rows and serializes them into a per-pixel on/off stream for one tile scanline.
- Takes a tile exponent (value 2^exp), expands it to 1–4 decimal digits and centres the digit string within the tile width.
- Fetches each digit's row from the font ROM (1-cycle registered latency), double-buffers it and shifts out pixels on pix_en.
- Sits between the tile-grid/VGA timing logic and the font ROM; its pixel_on feeds the colour mux.

---
 rtl/tile_render_pkg.sv | 52 +++++
 rtl/glyph_shifter.sv | 84 ++++++++
 rtl/tile_digit_renderer.sv | 123 ++++++++++++
 tb/tb_tile_digit_renderer.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tile_render_pkg.sv
// Shared types, constants and the exponent-to-digit table for the tile digit renderer.
// DOUBLE_WIDTH_EN: when defined, every glyph bit spans two pixels (DW = 32).
package tile_render_pkg;

    typedef logic [3:0] digit_t;

    localparam int GLYPH_W    = 16;
    localparam int MAX_DIGITS = 4;
    localparam int MAX_EXP    = 11;

`ifdef DOUBLE_WIDTH_EN
    localparam int PIX_REP = 2;
`else
    localparam int PIX_REP = 1;
`endif
    localparam int DW = GLYPH_W * PIX_REP;

    typedef enum logic [1:0] {IDLE, FETCH, WAIT, RUN} fsm_state_t;

    // d[0] is the most significant digit; unused slots are zero
    typedef struct packed {
        logic [2:0]                count;
        digit_t [MAX_DIGITS-1:0]   d;
    } digits_t;

    function automatic digits_t exp_to_digits(input logic [3:0] e);
        digits_t     r;
        logic [15:0] bcd;
        logic [2:0]  n;
        case (e)
            4'd1:    begin n = 3'd1; bcd = 16'h2000; end
            4'd2:    begin n = 3'd1; bcd = 16'h4000; end
            4'd3:    begin n = 3'd1; bcd = 16'h8000; end
            4'd4:    begin n = 3'd2; bcd = 16'h1600; end
            4'd5:    begin n = 3'd2; bcd = 16'h3200; end
            4'd6:    begin n = 3'd2; bcd = 16'h6400; end
            4'd7:    begin n = 3'd3; bcd = 16'h1280; end
            4'd8:    begin n = 3'd3; bcd = 16'h2560; end
            4'd9:    begin n = 3'd3; bcd = 16'h5120; end
            4'd10:   begin n = 3'd4; bcd = 16'h1024; end
            4'd11:   begin n = 3'd4; bcd = 16'h2048; end
            default: begin n = 3'd0; bcd = 16'h0000; end
        endcase
        r.count = n;
        r.d     = '0;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            r.d[i] = bcd[15-4*i -: 4];
        end
        return r;
    endfunction

endpackage

// File: rtl/glyph_shifter.sv
// Glyph row double buffer: holds the prefetched row, shifts it out MSB first with
// optional bit repeat, and flags pixels consumed before their row arrived.
module glyph_shifter
    import tile_render_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               cap,
    input  logic [GLYPH_W-1:0] cap_row,
    input  logic               consume,
    output logic               load,
    output logic               pix,
    output logic               underrun
);
    localparam int SW = $clog2(DW + 1);
    localparam int RW = $clog2(PIX_REP + 1);

    logic [GLYPH_W-1:0] nbuf_q;
    logic [GLYPH_W-1:0] shreg_q;
    logic               nbuf_vld_q;
    logic [SW-1:0]      slots_q;
    logic [RW-1:0]      rep_q;
    logic               need_load;
    logic               rep_done;

    // shreg_q[MSB] is the bit currently on screen; rep_q counts its repeats so far
    always_comb begin
        need_load = (slots_q == '0);
        rep_done  = (rep_q == RW'(PIX_REP));
        load      = consume && need_load && nbuf_vld_q;
        pix       = 1'b0;
        if (consume) begin
            if (need_load)     pix = nbuf_vld_q & nbuf_q[GLYPH_W-1];
            else if (rep_done) pix = shreg_q[GLYPH_W-2];
            else               pix = shreg_q[GLYPH_W-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nbuf_q     <= '0;
            shreg_q    <= '0;
            nbuf_vld_q <= 1'b0;
            slots_q    <= '0;
            rep_q      <= '0;
            underrun   <= 1'b0;
        end else if (clear) begin
            nbuf_q     <= '0;
            shreg_q    <= '0;
            nbuf_vld_q <= 1'b0;
            slots_q    <= '0;
            rep_q      <= '0;
            underrun   <= 1'b0;
        end else begin
            underrun <= consume && need_load && !nbuf_vld_q;
            if (consume) begin
                if (need_load) begin
                    // an unloaded glyph stays pending so it starts as soon as data lands
                    if (nbuf_vld_q) begin
                        shreg_q <= nbuf_q;
                        slots_q <= SW'(DW - 1);
                        rep_q   <= RW'(1);
                    end
                end else begin
                    slots_q <= slots_q - SW'(1);
                    if (rep_done) begin
                        shreg_q <= shreg_q << 1;
                        rep_q   <= RW'(1);
                    end else begin
                        rep_q   <= rep_q + RW'(1);
                    end
                end
            end
            if (cap) begin
                nbuf_q     <= cap_row;
                nbuf_vld_q <= 1'b1;
            end else if (load) begin
                nbuf_vld_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/tile_digit_renderer.sv
// Tile digit renderer: expands a tile exponent into centred decimal glyphs and streams
// one scanline of font pixels. Define DOUBLE_WIDTH_EN for two-pixel-wide glyph bits.
module tile_digit_renderer #(
    parameter int TILE_W  = 128,
    parameter int GLYPH_W = 16,
    parameter int VCNT_W  = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               line_start,
    input  logic [3:0]         tile_exp,
    input  logic [VCNT_W-1:0]  glyph_row,
    input  logic               pix_en,
    output logic [3:0]         font_number,
    output logic [VCNT_W-1:0]  font_v_cnt,
    input  logic [GLYPH_W-1:0] font_row,
    output logic               pixel_on,
    output logic               busy,
    output logic               underrun
);
    import tile_render_pkg::*;

    localparam int PW = $clog2(TILE_W) + 1;

    fsm_state_t              state_q, state_d;
    digits_t                 dec;
    digit_t [MAX_DIGITS-1:0] digits_q;
    logic [2:0]              ndig_q, idx_q, idx_d, next_idx;
    logic [VCNT_W-1:0]       row_q;
    logic [PW-1:0]           pcnt_q, lead_q, gend_q, lead_d, glen_d;
    logic                    consume, in_glyph, last_pix, cap, sh_load, sh_pix_p0;

    assign busy = (state_q != IDLE);

    always_comb begin
        dec      = exp_to_digits(tile_exp);
        glen_d   = PW'(int'(dec.count) * DW);
        lead_d   = PW'((TILE_W - int'(dec.count) * DW) / 2);
        consume  = busy && pix_en && !line_start;
        in_glyph = (pcnt_q >= lead_q) && (pcnt_q < gend_q);
        last_pix = (pcnt_q == PW'(TILE_W - 1));
        next_idx = idx_q + 3'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // A shifter load frees the next-buffer, which immediately triggers the next digit fetch
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cap     = 1'b0;
        case (state_q)
            IDLE:    ;
            FETCH:   state_d = WAIT;
            WAIT:    begin cap = 1'b1; state_d = RUN; end
            RUN:     if (sh_load && (next_idx < ndig_q)) begin
                         state_d = FETCH;
                         idx_d   = next_idx;
                     end
            default: state_d = IDLE;
        endcase
        if (consume && last_pix) state_d = IDLE;
        if (line_start) begin
            idx_d   = '0;
            state_d = (dec.count != 3'd0) ? FETCH : RUN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digits_q    <= '0;
            ndig_q      <= '0;
            row_q       <= '0;
            pcnt_q      <= '0;
            lead_q      <= '0;
            gend_q      <= '0;
            font_number <= '0;
            font_v_cnt  <= '0;
            pixel_on    <= 1'b0;
        end else begin
            if (line_start) begin
                digits_q <= dec.d;
                ndig_q   <= dec.count;
                row_q    <= glyph_row;
                pcnt_q   <= '0;
                lead_q   <= lead_d;
                gend_q   <= lead_d + glen_d;
                pixel_on <= 1'b0;
            end else if (consume) begin
                pcnt_q   <= pcnt_q + PW'(1);
                pixel_on <= in_glyph && sh_pix_p0;
            end else if (state_q == IDLE) begin
                pixel_on <= 1'b0;
            end
            // ROM request is held between fetches so a blank line leaves it untouched
            if (state_d == FETCH) begin
                font_number <= line_start ? dec.d[0] : digits_q[idx_d[1:0]];
                font_v_cnt  <= line_start ? glyph_row : row_q;
            end
        end
    end

    glyph_shifter u_shifter (
        .clk      (clk),
        .rst      (rst),
        .clear    (line_start),
        .cap      (cap),
        .cap_row  (font_row),
        .consume  (consume && in_glyph),
        .load     (sh_load),
        .pix      (sh_pix_p0),
        .underrun (underrun)
    );

endmodule

// File: tb/tb_tile_digit_renderer.sv
// Self-checking bench for tile_digit_renderer: random font ROM, scanline streams
// compared against a decimal-expansion reference model.
module tb_tile_digit_renderer;

    localparam int TILE_W  = 128;
    localparam int GLYPH_W = 16;
`ifdef DOUBLE_WIDTH_EN
    localparam int REP = 2;
`else
    localparam int REP = 1;
`endif
    localparam int DW = GLYPH_W * REP;

    logic        clk = 1'b0;
    logic        rst;
    logic        line_start;
    logic [3:0]  tile_exp;
    logic [11:0] glyph_row;
    logic        pix_en;
    logic [3:0]  font_number;
    logic [11:0] font_v_cnt;
    logic [15:0] font_row;
    logic        pixel_on;
    logic        busy;
    logic        underrun;

    int checks = 0;
    int errors = 0;

    logic [15:0] rom [0:15][0:15];

    logic        obs_pix  [0:TILE_W-1];
    logic        obs_busy [0:TILE_W-1];
    logic [3:0]  obs_fn   [0:TILE_W-1];
    logic [11:0] obs_fv   [0:TILE_W-1];
    logic [3:0]  fn_first;
    int          und_cnt;

    tile_digit_renderer dut (
        .clk         (clk),
        .rst         (rst),
        .line_start  (line_start),
        .tile_exp    (tile_exp),
        .glyph_row   (glyph_row),
        .pix_en      (pix_en),
        .font_number (font_number),
        .font_v_cnt  (font_v_cnt),
        .font_row    (font_row),
        .pixel_on    (pixel_on),
        .busy        (busy),
        .underrun    (underrun)
    );

    always #5 clk = ~clk;

    // Font ROM with one cycle of registered latency
    always @(posedge clk) font_row <= rom[font_number][font_v_cnt[3:0]];

    function automatic int model_ndig(input int e);
        int v, n;
        n = 0;
        if (e >= 1 && e <= 11) begin
            v = 1 << e;
            while (v > 0) begin n++; v /= 10; end
        end
        return n;
    endfunction

    function automatic int model_digit(input int e, input int k);
        int v, n;
        n = model_ndig(e);
        v = 1 << e;
        repeat (n - 1 - k) v /= 10;
        return v % 10;
    endfunction

    function automatic logic model_pix(input int e, input int row, input int p);
        int n, lead, g;
        logic [15:0] w;
        n    = model_ndig(e);
        lead = (TILE_W - n * DW) / 2;
        if (p < lead || p >= lead + n * DW) return 1'b0;
        g = p - lead;
        w = rom[model_digit(e, g / DW)][row % 16];
        return w[GLYPH_W - 1 - (g % DW) / REP];
    endfunction

    task automatic start_line(input logic [3:0] e, input logic [11:0] r, input logic with_pix);
        tile_exp   = e;
        glyph_row  = r;
        line_start = 1'b1;
        pix_en     = with_pix;
        @(posedge clk); #1;
        line_start = 1'b0;
        pix_en     = 1'b0;
    endtask

    task automatic stream(input int pre, input bit gaps, input int npix);
        und_cnt  = 0;
        fn_first = font_number;
        repeat (pre) begin
            @(posedge clk); #1;
            if (underrun === 1'b1) und_cnt++;
        end
        for (int p = 0; p < npix; p++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk); #1;
                    if (underrun === 1'b1) und_cnt++;
                end
            end
            pix_en = 1'b1;
            @(posedge clk); #1;
            pix_en      = 1'b0;
            obs_pix[p]  = pixel_on;
            obs_busy[p] = busy;
            obs_fn[p]   = font_number;
            obs_fv[p]   = font_v_cnt;
            if (underrun === 1'b1) und_cnt++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; line_start = 1'b0; pix_en = 1'b0; tile_exp = '0; glyph_row = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (pixel_on !== 1'b0) begin errors++; $display("FAIL reset_pixel_on got %b want 0", pixel_on); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun got %b want 0", underrun); end
        checks++; if (font_number !== 4'd0) begin errors++; $display("FAIL reset_font_number got %0d want 0", font_number); end
        checks++; if (font_v_cnt !== 12'd0) begin errors++; $display("FAIL reset_font_v_cnt got %0d want 0", font_v_cnt); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midline;
        start_line(4'd1, 12'd4, 1'b0);
        stream(2, 0, 40);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midline_busy_before got %b want 1", busy); end
        #2 rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midline_rst_busy got %b want 0", busy); end
        checks++; if (pixel_on !== 1'b0) begin errors++; $display("FAIL midline_rst_pixel_on got %b want 0", pixel_on); end
        checks++; if (font_v_cnt !== 12'd0) begin errors++; $display("FAIL midline_rst_font_v_cnt got %0d want 0", font_v_cnt); end
        checks++; if (font_number !== 4'd0) begin errors++; $display("FAIL midline_rst_font_number got %0d want 0", font_number); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        start_line(4'd1, 12'd4, 1'b0);
        stream(2, 0, TILE_W);
        for (int p = 0; p < TILE_W; p++) begin
            checks++;
            if (obs_pix[p] !== model_pix(1, 4, p)) begin
                errors++; $display("FAIL after_rst_pix[%0d] got %b want %b", p, obs_pix[p], model_pix(1, 4, p));
            end
        end
    endtask

    task automatic test_exp1;
        logic [15:0] word;
        start_line(4'd1, 12'd4, 1'b0);
        stream(2, 0, TILE_W);
        checks++; if (fn_first !== 4'd2) begin errors++; $display("FAIL exp1_font_number got %0d want 2", fn_first); end
        checks++; if (obs_fv[0] !== 12'd4) begin errors++; $display("FAIL exp1_font_v_cnt got %0d want 4", obs_fv[0]); end
        for (int p = 0; p < TILE_W; p++) begin
            checks++;
            if (obs_pix[p] !== model_pix(1, 4, p)) begin
                errors++; $display("FAIL exp1_pix[%0d] got %b want %b", p, obs_pix[p], model_pix(1, 4, p));
            end
        end
`ifndef DOUBLE_WIDTH_EN
        for (int i = 0; i < 16; i++) word[15-i] = obs_pix[56+i];
        checks++; if (word !== 16'h3FFC) begin errors++; $display("FAIL exp1_glyph_word got %h want 3ffc", word); end
`endif
        checks++; if (obs_busy[TILE_W-2] !== 1'b1) begin errors++; $display("FAIL exp1_busy_before_last got %b want 1", obs_busy[TILE_W-2]); end
        checks++; if (obs_busy[TILE_W-1] !== 1'b0) begin errors++; $display("FAIL exp1_busy_after_last got %b want 0", obs_busy[TILE_W-1]); end
        checks++; if (und_cnt !== 0) begin errors++; $display("FAIL exp1_underrun got %0d want 0", und_cnt); end
    endtask

    task automatic test_exp11;
        int lead;
        lead = (TILE_W - 4 * DW) / 2;
        start_line(4'd11, 12'h014, 1'b0);
        stream(2, 0, TILE_W);
        checks++; if (fn_first !== 4'd2) begin errors++; $display("FAIL exp11_fn0 got %0d want 2", fn_first); end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (obs_fn[lead + DW*k] !== 4'(model_digit(11, k + 1))) begin
                errors++; $display("FAIL exp11_fn%0d got %0d want %0d", k + 1, obs_fn[lead + DW*k], model_digit(11, k + 1));
            end
        end
        for (int p = 0; p < TILE_W; p++) begin
            checks++;
            if (obs_pix[p] !== model_pix(11, 'h14, p)) begin
                errors++; $display("FAIL exp11_pix[%0d] got %b want %b", p, obs_pix[p], model_pix(11, 'h14, p));
            end
        end
        checks++; if (und_cnt !== 0) begin errors++; $display("FAIL exp11_underrun got %0d want 0", und_cnt); end
        checks++; if (obs_busy[TILE_W-1] !== 1'b0) begin errors++; $display("FAIL exp11_busy_end got %b want 0", obs_busy[TILE_W-1]); end
    endtask

    task automatic test_blank;
        logic [3:0]  fn0;
        logic [11:0] fv0;
        int e;
        for (int t = 0; t < 2; t++) begin
            e   = (t == 0) ? 0 : 13;
            fn0 = font_number;
            fv0 = font_v_cnt;
            start_line(4'(e), 12'h3A5, 1'b0);
            stream(2, 1, TILE_W);
            for (int p = 0; p < TILE_W; p++) begin
                checks++;
                if (obs_pix[p] !== 1'b0) begin errors++; $display("FAIL blank%0d_pix[%0d] got %b want 0", e, p, obs_pix[p]); end
            end
            checks++; if (obs_fn[TILE_W-1] !== fn0) begin errors++; $display("FAIL blank%0d_font_number got %0d want %0d", e, obs_fn[TILE_W-1], fn0); end
            checks++; if (obs_fv[TILE_W-1] !== fv0) begin errors++; $display("FAIL blank%0d_font_v_cnt got %0d want %0d", e, obs_fv[TILE_W-1], fv0); end
            checks++; if (obs_busy[TILE_W-1] !== 1'b0) begin errors++; $display("FAIL blank%0d_busy_end got %b want 0", e, obs_busy[TILE_W-1]); end
        end
    endtask

    task automatic test_abort;
        start_line(4'd10, 12'd7, 1'b0);
        stream(2, 0, 50);
        start_line(4'd3, 12'd9, 1'b1);
        checks++; if (font_number !== 4'd8) begin errors++; $display("FAIL abort_font_number got %0d want 8", font_number); end
        stream(2, 0, TILE_W);
        for (int p = 0; p < TILE_W; p++) begin
            checks++;
            if (obs_pix[p] !== model_pix(3, 9, p)) begin
                errors++; $display("FAIL abort_pix[%0d] got %b want %b", p, obs_pix[p], model_pix(3, 9, p));
            end
        end
        checks++; if (und_cnt !== 0) begin errors++; $display("FAIL abort_underrun got %0d want 0", und_cnt); end
    endtask

    task automatic test_early_pix;
        start_line(4'd11, 12'd2, 1'b0);
        stream(0, 0, TILE_W);
`ifdef DOUBLE_WIDTH_EN
        checks++; if (und_cnt == 0) begin errors++; $display("FAIL early_underrun got %0d want nonzero", und_cnt); end
        checks++; if (obs_pix[0] !== 1'b0) begin errors++; $display("FAIL early_pix0 got %b want 0", obs_pix[0]); end
`else
        checks++; if (und_cnt !== 0) begin errors++; $display("FAIL early_underrun got %0d want 0", und_cnt); end
        for (int p = 0; p < TILE_W; p++) begin
            checks++;
            if (obs_pix[p] !== model_pix(11, 2, p)) begin
                errors++; $display("FAIL early_pix[%0d] got %b want %b", p, obs_pix[p], model_pix(11, 2, p));
            end
        end
`endif
    endtask

    task automatic test_idle_pix;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            pix_en = 1'b1;
            @(posedge clk); #1;
            checks++; if (pixel_on !== 1'b0) begin errors++; $display("FAIL idle_pixel_on[%0d] got %b want 0", i, pixel_on); end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy[%0d] got %b want 0", i, busy); end
        end
        pix_en = 1'b0;
    endtask

    task automatic test_random;
        int e, r;
        for (int n = 0; n < 8; n++) begin
            e = $urandom_range(0, 15);
            r = $urandom_range(0, 4095);
            start_line(4'(e), 12'(r), 1'b0);
            stream($urandom_range(2, 4), 1, TILE_W);
            for (int p = 0; p < TILE_W; p++) begin
                checks++;
                if (obs_pix[p] !== model_pix(e, r, p)) begin
                    errors++; $display("FAIL rand%0d_exp%0d_pix[%0d] got %b want %b", n, e, p, obs_pix[p], model_pix(e, r, p));
                end
            end
            checks++; if (und_cnt !== 0) begin errors++; $display("FAIL rand%0d_underrun got %0d want 0", n, und_cnt); end
            checks++; if (obs_busy[TILE_W-1] !== 1'b0) begin errors++; $display("FAIL rand%0d_busy_end got %b want 0", n, obs_busy[TILE_W-1]); end
        end
    endtask

    task automatic test_back_to_back;
        int e;
        for (int n = 0; n < 3; n++) begin
            e = 9 + n;
            start_line(4'(e), 12'(n), 1'b0);
            stream(2, 0, TILE_W);
            for (int p = 0; p < TILE_W; p++) begin
                checks++;
                if (obs_pix[p] !== model_pix(e, n, p)) begin
                    errors++; $display("FAIL b2b%0d_pix[%0d] got %b want %b", n, p, obs_pix[p], model_pix(e, n, p));
                end
            end
        end
    endtask

    initial begin
        for (int n = 0; n < 16; n++)
            for (int r = 0; r < 16; r++)
                rom[n][r] = 16'($urandom);
        rom[2][4] = 16'h3FFC;

        test_reset;
        test_reset_midline;
        test_exp1;
        test_exp11;
        test_blank;
        test_abort;
        test_early_pix;
        test_idle_pix;
        test_random;
        test_back_to_back;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
